// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link (receiver and transmitter sides).
package serial_link_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    // Line levels of the framed serial protocol
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out data path: shifts Di in on shift_en, either LSB- or MSB-first.
module sipo_shift_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             Di,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shifted;

    // Shifted value; a single-bit register simply captures Di in either order
    generate
        if (WIDTH == 1) begin : g_single
            always_comb shifted = Di;
        end else if (MSB_FIRST) begin : g_msb_first
            always_comb shifted = {q_q[WIDTH-2:0], Di};
        end else begin : g_lsb_first
            always_comb shifted = {Di, q_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state: shift only when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            q_d = shifted;
        end
    end

    // Register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start bit, WIDTH data bits, stop bit; sampled on bit strobes.
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Di,
    input  logic             bit_en,
    output logic [WIDTH-1:0] Do,
    output logic             Do_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic             do_valid_q, do_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             shift_en;
    logic [WIDTH-1:0] sreg;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .Di       (Di),
        .q        (sreg)
    );

    // Frame sequencing, bit counting and output capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        do_d        = do_q;
        do_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_en && Di == START_LEVEL) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // A low stop bit returns to IDLE; it is never reused as a start bit
                if (bit_en) begin
                    state_d = IDLE;
                    if (Di == STOP_LEVEL) begin
                        do_d       = sreg;
                        do_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            do_q        <= '0;
            do_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            do_q        <= do_d;
            do_valid_q  <= do_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign Do        = do_q;
    assign Do_valid  = do_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver, LSB-first and MSB-first instances side by side.
module tb_serial_frame_receiver;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    logic Di;
    logic bit_en;

    logic [W-1:0] do_l, do_m;
    logic         v_l, v_m, e_l, e_m, b_l, b_m;

    always #5 clk = ~clk;

    serial_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .Di(Di), .bit_en(bit_en),
        .Do(do_l), .Do_valid(v_l), .frame_err(e_l), .busy(b_l)
    );

    serial_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .Di(Di), .bit_en(bit_en),
        .Do(do_m), .Do_valid(v_m), .frame_err(e_m), .busy(b_m)
    );

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } exp_t;

    exp_t   q_l[$];
    exp_t   q_m[$];
    int     pulse_cyc[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    logic [W-1:0] last_l, last_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Monitor: LSB-first instance
    always @(negedge clk) begin
        if (v_l || e_l) begin
            exp_t e;
            check("lsb_exclusive", {31'b0, v_l & e_l}, 32'd0);
            if (q_l.size() == 0) begin
                check("lsb_unexpected_pulse", {30'b0, v_l, e_l}, 32'd0);
            end else begin
                e = q_l.pop_front();
                check("lsb_frame_err", {31'b0, e_l}, {31'b0, e.err});
                check("lsb_do_valid", {31'b0, v_l}, {31'b0, ~e.err});
                check("lsb_do", {28'b0, do_l}, {28'b0, e.data});
            end
            if (v_l) pulse_cyc.push_back(cyc);
        end
    end

    // Monitor: MSB-first instance
    always @(negedge clk) begin
        if (v_m || e_m) begin
            exp_t e;
            check("msb_exclusive", {31'b0, v_m & e_m}, 32'd0);
            if (q_m.size() == 0) begin
                check("msb_unexpected_pulse", {30'b0, v_m, e_m}, 32'd0);
            end else begin
                e = q_m.pop_front();
                check("msb_frame_err", {31'b0, e_m}, {31'b0, e.err});
                check("msb_do_valid", {31'b0, v_m}, {31'b0, ~e.err});
                check("msb_do", {28'b0, do_m}, {28'b0, e.data});
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    // One strobe; during the gap Di is driven to the opposite level to prove it is ignored
    task automatic send_bit(input logic b, input int gap);
        Di     = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        if (gap > 0) begin
            bit_en = 1'b0;
            Di     = ~b;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic stop, input int gap);
        exp_t el, em;
        el.err = ~stop; em.err = ~stop;
        el.data = stop ? data : last_l;
        em.data = stop ? rev(data) : last_m;
        q_l.push_back(el);
        q_m.push_back(em);
        send_bit(1'b0, gap);
        check("busy_after_start", {30'b0, b_l, b_m}, 32'd3);
        for (int i = 0; i < int'(W); i++) send_bit(data[i], gap);
        send_bit(stop, gap);
        check("busy_after_stop", {30'b0, b_l, b_m}, 32'd0);
        if (stop) begin
            last_l = data;
            last_m = rev(data);
        end
    endtask

    task automatic go_idle();
        bit_en = 1'b0;
        Di     = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; Di = 1'b1; bit_en = 1'b0;
        last_l = '0; last_m = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_do", {24'b0, do_l, do_m}, 32'd0);
        check("rst_pulses", {28'b0, v_l, v_m, e_l, e_m}, 32'd0);
        check("rst_busy", {30'b0, b_l, b_m}, 32'd0);

        // 1. Idle line with strobes every cycle
        Di = 1'b1; bit_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_busy", {30'b0, b_l, b_m}, 32'd0);
            check("idle_do", {24'b0, do_l, do_m}, 32'd0);
        end
        go_idle();

        // 2. Single frame 0xD, strobe every cycle
        send_frame(4'hD, 1'b1, 0);
        go_idle();
        check("t2_do_lsb", {28'b0, do_l}, 32'hD);
        check("t2_do_msb", {28'b0, do_m}, 32'hB);

        // 3. Same frame with sparse strobes (1 in 3)
        send_frame(4'hD, 1'b1, 2);
        go_idle();
        check("t3_do_lsb", {28'b0, do_l}, 32'hD);
        check("t3_do_msb", {28'b0, do_m}, 32'hB);

        // 4. Framing error, data 1,0,1,0 then stop=0
        send_frame(4'h5, 1'b0, 0);
        go_idle();
        check("t4_do_hold_lsb", {28'b0, do_l}, 32'hD);
        check("t4_do_hold_msb", {28'b0, do_m}, 32'hB);
        check("t4_busy", {30'b0, b_l, b_m}, 32'd0);

        // 5. Back-to-back 0xA then 0x5
        @(negedge clk);
        pulse_cyc.delete();
        @(posedge clk); #1;
        send_frame(4'hA, 1'b1, 0);
        send_frame(4'h5, 1'b1, 0);
        go_idle();
        @(negedge clk);
        check("t5_pulse_count", pulse_cyc.size(), 32'd2);
        if (pulse_cyc.size() == 2)
            check("t5_pulse_spacing", pulse_cyc[1] - pulse_cyc[0], W + 2);
        check("t5_do_lsb", {28'b0, do_l}, 32'h5);
        check("t5_do_msb", {28'b0, do_m}, 32'hA);
        @(posedge clk); #1;

        // 6. Reset mid-frame, with a start-level strobe held during reset
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1; Di = 1'b0; bit_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bit_en = 1'b0; Di = 1'b1;
        last_l = '0; last_m = '0;
        check("t6_do_after_rst", {24'b0, do_l, do_m}, 32'd0);
        check("t6_busy_after_rst", {30'b0, b_l, b_m}, 32'd0);
        @(posedge clk); #1;
        send_frame(4'h3, 1'b1, 0);
        go_idle();
        check("t6_do_lsb", {28'b0, do_l}, 32'h3);
        check("t6_do_msb", {28'b0, do_m}, 32'hC);

        // Drain: every queued expectation must have been matched by a pulse
        repeat (3) @(negedge clk);
        check("scoreboard_empty", q_l.size() + q_m.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
